// File: rtl/per2axi_sched_pkg.sv
// Shared types for the per2axi outstanding-transaction scheduler:
// per-slot transaction state and the R/B round-robin pointer encoding.
package per2axi_sched_pkg;

  typedef enum logic [2:0] {
    SLOT_FREE      = 3'd0,
    SLOT_RD_PEND   = 3'd1,
    SLOT_WR_PEND   = 3'd2,
    SLOT_AT_BOTH   = 3'd3,
    SLOT_AT_WAIT_R = 3'd4,
    SLOT_AT_WAIT_B = 3'd5
  } slot_state_t;

  // Pointer remembers which channel was served last; the other one wins a tie.
  localparam logic RR_LAST_R = 1'b0;
  localparam logic RR_LAST_B = 1'b1;

endpackage

// File: rtl/per2axi_rr_arb2.sv
// Two-input round-robin arbiter (bit 0 = R, bit 1 = B), zero-latency grant.
// The pointer moves only when a grant is given; reset favours input 0 on a tie.
module per2axi_rr_arb2
  import per2axi_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    case (valid_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_q == RR_LAST_B) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= RR_LAST_B;
    end else if (|gnt_o) begin
      last_q <= gnt_o[1] ? RR_LAST_B : RR_LAST_R;
    end
  end

endmodule

// File: rtl/per2axi_outstanding_ctrl.sv
// per2axi scheduler: one outstanding transaction per ID slot, global cap, R/B round-robin.
// Optional PER2AXI_OUTSTANDING_PERF_EN adds saturating grant/stall counters.
module per2axi_outstanding_ctrl
  import per2axi_sched_pkg::*;
#(
  parameter int NB_SLOTS        = 5,
  parameter int AXI_ID_WIDTH    = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  input  logic [AXI_ID_WIDTH-1:0] req_id_i,
  input  logic                    req_we_i,
  input  logic                    req_atop_i,
  input  logic                    req_add2_i,
  output logic                    req_gnt_o,
  input  logic                    r_valid_i,
  input  logic [AXI_ID_WIDTH-1:0] r_id_i,
  output logic                    r_ready_o,
  input  logic                    b_valid_i,
  input  logic [AXI_ID_WIDTH-1:0] b_id_i,
  output logic                    b_ready_o,
  output logic                    resp_valid_o,
  output logic                    resp_sel_b_o,
  output logic [NB_SLOTS-1:0]     resp_id_o,
  output logic                    resp_hi_o,
  output logic                    err_unexpected_o,
  output logic [CNT_WIDTH-1:0]    outstanding_o,
  output logic                    idle_o,
  output logic [31:0]             perf_req_o,
  output logic [31:0]             perf_stall_o
);

  slot_state_t           slot_q [NB_SLOTS];
  slot_state_t           slot_d [NB_SLOTS];
  logic [NB_SLOTS-1:0]   add2_q, add2_d;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [1:0]            arb_gnt;
  logic                  serve_r, serve_b, serve;
  logic [AXI_ID_WIDTH-1:0] served_id;
  slot_state_t           cur_state, nxt_state;
  logic                  req_free, served_add2, fwd, err, to_free;

  per2axi_rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i ({b_valid_i, r_valid_i}),
    .gnt_o   (arb_gnt)
  );

  assign serve_r   = arb_gnt[0];
  assign serve_b   = arb_gnt[1];
  assign serve     = serve_r | serve_b;
  assign served_id = serve_b ? b_id_i : r_id_i;
  assign r_ready_o = serve_r;
  assign b_ready_o = serve_b;

  // Out-of-range IDs match no slot, so they are never granted and always flagged.
  always_comb begin
    req_free    = 1'b0;
    cur_state   = SLOT_FREE;
    served_add2 = 1'b0;
    for (int i = 0; i < NB_SLOTS; i++) begin
      if (req_id_i == AXI_ID_WIDTH'(i)) req_free = (slot_q[i] == SLOT_FREE);
      if (served_id == AXI_ID_WIDTH'(i)) begin
        cur_state   = slot_q[i];
        served_add2 = add2_q[i];
      end
    end
  end

  assign req_gnt_o = req_valid_i & req_free & (count_q < CNT_WIDTH'(MAX_OUTSTANDING));

  always_comb begin
    nxt_state = cur_state;
    fwd       = 1'b0;
    err       = 1'b0;
    if (serve_r) begin
      case (cur_state)
        SLOT_RD_PEND:   begin nxt_state = SLOT_FREE;      fwd = 1'b1; end
        SLOT_AT_BOTH:   begin nxt_state = SLOT_AT_WAIT_B; fwd = 1'b1; end
        SLOT_AT_WAIT_R: begin nxt_state = SLOT_FREE;      fwd = 1'b1; end
        default:        err = 1'b1;
      endcase
    end else if (serve_b) begin
      // Atomic B completes bookkeeping only; the core sees the R beat.
      case (cur_state)
        SLOT_WR_PEND:   begin nxt_state = SLOT_FREE;      fwd = 1'b1; end
        SLOT_AT_BOTH:   nxt_state = SLOT_AT_WAIT_R;
        SLOT_AT_WAIT_B: nxt_state = SLOT_FREE;
        default:        err = 1'b1;
      endcase
    end
  end

  assign to_free = serve & ~err & (nxt_state == SLOT_FREE);

  always_comb begin
    add2_d    = add2_q;
    resp_id_o = '0;
    for (int i = 0; i < NB_SLOTS; i++) begin
      slot_d[i] = slot_q[i];
      if (serve && !err && served_id == AXI_ID_WIDTH'(i)) slot_d[i] = nxt_state;
      if (req_gnt_o && req_id_i == AXI_ID_WIDTH'(i)) begin
        slot_d[i] = req_atop_i ? SLOT_AT_BOTH : (req_we_i ? SLOT_WR_PEND : SLOT_RD_PEND);
        add2_d[i] = req_add2_i;
      end
      resp_id_o[i] = fwd && (served_id == AXI_ID_WIDTH'(i));
    end
  end

  assign resp_valid_o     = fwd;
  assign resp_sel_b_o     = fwd & serve_b;
  assign resp_hi_o        = fwd & serve_r & served_add2;
  assign err_unexpected_o = err;
  assign outstanding_o    = count_q;
  assign idle_o           = (count_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NB_SLOTS; i++) slot_q[i] <= SLOT_FREE;
      add2_q  <= '0;
      count_q <= '0;
    end else begin
      slot_q <= slot_d;
      add2_q <= add2_d;
      case ({req_gnt_o, to_free})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef PER2AXI_OUTSTANDING_PERF_EN
  logic [31:0] perf_req_q, perf_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_req_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (req_gnt_o && perf_req_q != '1) perf_req_q <= perf_req_q + 1'b1;
      if (req_valid_i && !req_gnt_o && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_req_o   = perf_req_q;
  assign perf_stall_o = perf_stall_q;
`else
  assign perf_req_o   = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_per2axi_outstanding_ctrl.sv
// Bench for per2axi_outstanding_ctrl: directed scenarios plus randomized traffic
// compared against a per-slot "which responses are still owed" reference model.
module tb_per2axi_outstanding_ctrl;

  localparam int NS   = 5;
  localparam int MAXO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid, req_we, req_atop, req_add2, r_valid, b_valid;
  logic [2:0] req_id, r_id, b_id;
  logic       req_gnt, r_ready, b_ready, resp_valid, resp_sel_b, resp_hi, err_unexp, idle;
  logic [4:0] resp_id;
  logic [2:0] outstanding;
  logic [31:0] perf_req, perf_stall;

  int checks = 0;
  int errors = 0;

  // Reference model: per slot, which response channels are still owed.
  bit need_r [8];
  bit need_b [8];
  bit atom   [8];
  bit add2m  [8];
  bit last_b;
  bit m_sr, m_sb, legit;
  int sid;
  bit e_gnt, e_fwd, e_selb, e_hi, e_err;
  logic [4:0] e_id;

  per2axi_outstanding_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_id_i         (req_id),
    .req_we_i         (req_we),
    .req_atop_i       (req_atop),
    .req_add2_i       (req_add2),
    .req_gnt_o        (req_gnt),
    .r_valid_i        (r_valid),
    .r_id_i           (r_id),
    .r_ready_o        (r_ready),
    .b_valid_i        (b_valid),
    .b_id_i           (b_id),
    .b_ready_o        (b_ready),
    .resp_valid_o     (resp_valid),
    .resp_sel_b_o     (resp_sel_b),
    .resp_id_o        (resp_id),
    .resp_hi_o        (resp_hi),
    .err_unexpected_o (err_unexp),
    .outstanding_o    (outstanding),
    .idle_o           (idle),
    .perf_req_o       (perf_req),
    .perf_stall_o     (perf_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  function automatic int busy_cnt();
    int n = 0;
    for (int i = 0; i < NS; i++) if (need_r[i] || need_b[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      need_r[i] = 0; need_b[i] = 0; atom[i] = 0; add2m[i] = 0;
    end
    last_b = 1;
  endtask

  task automatic model_comb();
    m_sr  = r_valid && (!b_valid || last_b);
    m_sb  = b_valid && !m_sr;
    e_gnt = req_valid && (req_id < NS) && !need_r[req_id] && !need_b[req_id] && (busy_cnt() < MAXO);
    sid   = m_sr ? int'(r_id) : int'(b_id);
    legit = (m_sr || m_sb) && (sid < NS) && (m_sr ? need_r[sid] : need_b[sid]);
    e_fwd  = legit && (m_sr || !atom[sid]);
    e_err  = (m_sr || m_sb) && !legit;
    e_selb = e_fwd && m_sb;
    e_hi   = e_fwd && m_sr && add2m[sid];
    e_id   = e_fwd ? (5'b00001 << sid) : 5'b00000;
  endtask

  task automatic model_commit();
    if (legit) begin
      if (m_sr) need_r[sid] = 0;
      else      need_b[sid] = 0;
    end
    if (e_gnt) begin
      need_r[req_id] = req_atop || !req_we;
      need_b[req_id] = req_atop || req_we;
      atom[req_id]   = req_atop;
      add2m[req_id]  = req_add2;
    end
    if (m_sr || m_sb) last_b = m_sb;
  endtask

  task automatic step();
    model_comb();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle_in();
    req_valid = 0; req_id = 0; req_we = 0; req_atop = 0; req_add2 = 0;
    r_valid = 0; r_id = 0; b_valid = 0; b_id = 0;
  endtask

  task automatic drv_req(input int id, input bit we, input bit atop, input bit add2);
    req_valid = 1; req_id = 3'(id); req_we = we; req_atop = atop; req_add2 = add2;
  endtask

  task automatic drv_r(input int id);
    r_valid = 1; r_id = 3'(id);
  endtask

  task automatic drv_b(input int id);
    b_valid = 1; b_id = 3'(id);
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if ({req_gnt, r_ready, b_ready, resp_valid, resp_sel_b, resp_id, resp_hi, err_unexp} !== 12'h000) begin
      errors++; $display("FAIL reset_outs: got %h want 000", {req_gnt, r_ready, b_ready, resp_valid, resp_sel_b, resp_id, resp_hi, err_unexp}); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", outstanding); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
    checks++; if ({perf_req, perf_stall} !== 64'd0) begin errors++; $display("FAIL reset_perf: got %h want 0", {perf_req, perf_stall}); end
  endtask

  task automatic test_read_add2();
    drv_req(2, 0, 0, 1); #1;
    checks++; if (req_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", req_gnt); end
    step(); idle_in(); #1;
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL rd_cnt1: got %0d want 1", outstanding); end
    step(); drv_r(2); #1;
    checks++; if ({r_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL rd_ready: got %b want 10", {r_ready, b_ready}); end
    checks++; if ({resp_valid, resp_sel_b, resp_hi} !== 3'b101) begin errors++; $display("FAIL rd_resp: got %b want 101", {resp_valid, resp_sel_b, resp_hi}); end
    checks++; if (resp_id !== 5'b00100) begin errors++; $display("FAIL rd_id: got %b want 00100", resp_id); end
    step(); idle_in(); #1;
    checks++; if ({outstanding, idle} !== 4'b0001) begin errors++; $display("FAIL rd_done: got cnt=%0d idle=%b want 0/1", outstanding, idle); end
  endtask

  task automatic test_write_block();
    drv_req(1, 1, 0, 0); #1;
    checks++; if (req_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", req_gnt); end
    step(); #1;
    checks++; if (req_gnt !== 1'b0) begin errors++; $display("FAIL wr_busy1: got %b want 0", req_gnt); end
    step(); drv_b(1); #1;
    checks++; if (req_gnt !== 1'b0) begin errors++; $display("FAIL wr_busy2: got %b want 0", req_gnt); end
    checks++; if ({b_ready, resp_valid, resp_sel_b} !== 3'b111) begin errors++; $display("FAIL wr_b: got %b want 111", {b_ready, resp_valid, resp_sel_b}); end
    checks++; if (resp_id !== 5'b00010) begin errors++; $display("FAIL wr_id: got %b want 00010", resp_id); end
    step(); b_valid = 0; #1;
    checks++; if (req_gnt !== 1'b1) begin errors++; $display("FAIL wr_regnt: got %b want 1", req_gnt); end
    step(); idle_in(); drv_b(1); #1;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL wr_b2: got %b want 1", resp_valid); end
    step(); idle_in();
  endtask

  task automatic test_atomic();
    drv_req(3, 0, 1, 1); #1;
    checks++; if (req_gnt !== 1'b1) begin errors++; $display("FAIL at_gnt: got %b want 1", req_gnt); end
    step(); idle_in(); drv_b(3); #1;
    checks++; if ({r_ready, b_ready, resp_valid, err_unexp} !== 4'b0100) begin errors++; $display("FAIL at_b: got %b want 0100", {r_ready, b_ready, resp_valid, err_unexp}); end
    step(); idle_in(); #1;
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL at_cnt: got %0d want 1", outstanding); end
    drv_r(3); #1;
    checks++; if ({r_ready, resp_valid, resp_sel_b, resp_hi} !== 4'b1101) begin errors++; $display("FAIL at_r: got %b want 1101", {r_ready, resp_valid, resp_sel_b, resp_hi}); end
    checks++; if (resp_id !== 5'b01000) begin errors++; $display("FAIL at_id: got %b want 01000", resp_id); end
    step(); idle_in(); #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL at_done: got %0d want 0", outstanding); end
  endtask

  task automatic test_unexpected();
    drv_b(2); #1;
    checks++; if ({b_ready, err_unexp, resp_valid} !== 3'b110) begin errors++; $display("FAIL ux_b: got %b want 110", {b_ready, err_unexp, resp_valid}); end
    step(); idle_in(); #1;
    checks++; if ({err_unexp, outstanding} !== 4'b0000) begin errors++; $display("FAIL ux_after: got err=%b cnt=%0d want 0/0", err_unexp, outstanding); end
    drv_r(6); #1;
    checks++; if ({r_ready, err_unexp, resp_valid, resp_id} !== 8'b11000000) begin errors++; $display("FAIL ux_rid6: got %b want 11000000", {r_ready, err_unexp, resp_valid, resp_id}); end
    step(); idle_in(); drv_req(2, 0, 0, 0); #1;
    checks++; if (req_gnt !== 1'b1) begin errors++; $display("FAIL ux_slotfree: got %b want 1", req_gnt); end
    step(); idle_in(); drv_r(2);
    step(); idle_in();
  endtask

  task automatic test_tie();
    do_reset();
    drv_req(0, 0, 0, 0); step();
    drv_req(4, 1, 0, 0); step();
    idle_in(); drv_r(0); drv_b(4); #1;
    checks++; if ({r_ready, b_ready, resp_id} !== 7'b1000001) begin errors++; $display("FAIL tie1: got %b want 1000001", {r_ready, b_ready, resp_id}); end
    step(); #1;
    checks++; if ({r_ready, b_ready, resp_sel_b, resp_id} !== 8'b01110000) begin errors++; $display("FAIL tie2: got %b want 01110000", {r_ready, b_ready, resp_sel_b, resp_id}); end
    step(); #1;
    checks++; if ({r_ready, b_ready, err_unexp} !== 3'b101) begin errors++; $display("FAIL tie3: got %b want 101", {r_ready, b_ready, err_unexp}); end
    step(); #1;
    checks++; if ({r_ready, b_ready, err_unexp} !== 3'b011) begin errors++; $display("FAIL tie4: got %b want 011", {r_ready, b_ready, err_unexp}); end
    step(); idle_in(); #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL tie_cnt: got %0d want 0", outstanding); end
  endtask

  task automatic test_max();
    for (int i = 0; i < 4; i++) begin
      drv_req(i, 0, 0, 0); #1;
      checks++; if (req_gnt !== 1'b1) begin errors++; $display("FAIL max_fill%0d: got %b want 1", i, req_gnt); end
      step();
    end
    drv_req(4, 0, 0, 0); #1;
    checks++; if ({req_gnt, outstanding} !== 4'b0100) begin errors++; $display("FAIL max_stall: got gnt=%b cnt=%0d want 0/4", req_gnt, outstanding); end
    step(); drv_r(0); #1;
    checks++; if ({req_gnt, resp_valid} !== 2'b01) begin errors++; $display("FAIL max_stall2: got %b want 01", {req_gnt, resp_valid}); end
    step(); drv_r(1); #1;
    checks++; if ({req_gnt, resp_valid, outstanding} !== 5'b11011) begin errors++; $display("FAIL max_both: got %b want 11011", {req_gnt, resp_valid, outstanding}); end
    step(); idle_in(); #1;
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL max_same: got %0d want 3", outstanding); end
    drv_req(0, 0, 0, 0); step(); idle_in(); drv_req(1, 0, 0, 0); #1;
    checks++; if ({req_gnt, outstanding} !== 4'b0100) begin errors++; $display("FAIL max_cap: got gnt=%b cnt=%0d want 0/4", req_gnt, outstanding); end
    step(); idle_in();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      idle_in();
      req_valid = ($urandom_range(0, 99) < 60);
      req_id    = 3'($urandom_range(0, 6));
      req_we    = $urandom_range(0, 1) == 1;
      req_atop  = ($urandom_range(0, 99) < 20);
      req_add2  = $urandom_range(0, 1) == 1;
      r_valid   = ($urandom_range(0, 99) < 45);
      r_id      = 3'($urandom_range(0, 5));
      b_valid   = ($urandom_range(0, 99) < 45);
      b_id      = 3'($urandom_range(0, 5));
      model_comb();
      #1;
      checks++; if (req_gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, req_gnt, e_gnt); end
      checks++; if ({r_ready, b_ready} !== {m_sr, m_sb}) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, {r_ready, b_ready}, {m_sr, m_sb}); end
      checks++; if ({resp_valid, resp_sel_b, resp_hi} !== {e_fwd, e_selb, e_hi}) begin errors++; $display("FAIL rnd_resp c%0d: got %b want %b", c, {resp_valid, resp_sel_b, resp_hi}, {e_fwd, e_selb, e_hi}); end
      checks++; if (resp_id !== e_id) begin errors++; $display("FAIL rnd_id c%0d: got %b want %b", c, resp_id, e_id); end
      checks++; if (err_unexp !== e_err) begin errors++; $display("FAIL rnd_err c%0d: got %b want %b", c, err_unexp, e_err); end
      checks++; if (outstanding !== 3'(busy_cnt())) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, outstanding, busy_cnt()); end
      checks++; if (idle !== (busy_cnt() == 0)) begin errors++; $display("FAIL rnd_idle c%0d: got %b want %b", c, idle, busy_cnt() == 0); end
      step();
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_read_add2();
    test_write_block();
    test_atomic();
    test_unexpected();
    test_tie();
    test_max();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
